display_writer: RTL and testbench

Command-driven framebuffer writer that fills clipped rectangles of a single 8-bit colour into `displayMemory` through its write port (`wr_en_display`, byte/half/full strobes, `writeAddress`, `writeData`). It is the producer side of the display memory, while `HDMI_display` is the consumer on the read port. It coalesces pixels into the widest aligned store each cycle, so a long row costs roughly a quarter as many write cycles as pixels.

---
 rtl/display_writer.sv | 137 +++++++++++++
 tb/tb_display_writer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_writer.sv
// rtl/display_writer.sv - clipped solid-rectangle filler for the display memory write port
// Issues one store per cycle, widening to half/full words whenever alignment and remaining width allow.
module display_writer #(
  parameter int          H_RES     = 640,
  parameter int          V_RES     = 480,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_x0,
  input  logic [8:0]  cmd_y0,
  input  logic [9:0]  cmd_w,
  input  logic [8:0]  cmd_h,
  input  logic [7:0]  cmd_color,
  output logic        busy,
  output logic        done,
  output logic        wr_en_display,
  output logic        byteWrite,
  output logic        half_wordWrite,
  output logic        full_wordWrite,
  output logic [31:0] writeAddress,
  output logic [31:0] writeData
);

  typedef enum logic [1:0] {IDLE, SETUP, WRITE, DONE} state_t;

  localparam logic [10:0] H_LIM = 11'(H_RES);
  localparam logic [10:0] V_LIM = 11'(V_RES);

  state_t      state, state_nx;
  logic [10:0] x0_q, y0_q, w_q, h_q;
  logic [10:0] x_end_q, y_end_q, x_q, y_q;
  logic [7:0]  color_q;
  logic        fin_q;

  logic [10:0] x_sum, y_sum, xe_c, ye_c;
  logic        empty_c;
  logic [10:0] sel_x, sel_y, sel_xe, sel_ye, rem, step, nx;
  logic        is_full, is_half, row_end, last, issue;
  logic [31:0] addr_c;

  logic rdy_d, busy_d, done_d, wr_d, bw_d, hw_d, fw_d;

  assign x_sum   = x0_q + w_q;
  assign y_sum   = y0_q + h_q;
  assign xe_c    = (x_sum > H_LIM) ? H_LIM : x_sum;
  assign ye_c    = (y_sum > V_LIM) ? V_LIM : y_sum;
  assign empty_c = (w_q == 11'd0) || (h_q == 11'd0) || (x0_q >= H_LIM) || (y0_q >= V_LIM);

  // During SETUP the first store comes straight from the freshly clipped command.
  assign sel_x   = (state == SETUP) ? x0_q : x_q;
  assign sel_y   = (state == SETUP) ? y0_q : y_q;
  assign sel_xe  = (state == SETUP) ? xe_c : x_end_q;
  assign sel_ye  = (state == SETUP) ? ye_c : y_end_q;
  assign rem     = sel_xe - sel_x;
  assign is_full = (sel_x[1:0] == 2'b00) && (rem >= 11'd4);
  assign is_half = !is_full && !sel_x[0] && (rem >= 11'd2);
  assign step    = is_full ? 11'd4 : (is_half ? 11'd2 : 11'd1);
  assign nx      = sel_x + step;
  assign row_end = (nx == sel_xe);
  assign last    = row_end && ((sel_y + 11'd1) == sel_ye);
  assign addr_c  = BASE_ADDR + 32'(sel_y) * 32'(H_RES) + 32'(sel_x);
  assign issue   = ((state == SETUP) && !empty_c) || ((state == WRITE) && !fin_q);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cmd_valid) state_nx = SETUP;
      SETUP:   state_nx = empty_c ? DONE : WRITE;
      WRITE:   if (fin_q) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rdy_d  = (state_nx == IDLE);
    busy_d = (state_nx != IDLE);
    done_d = (state_nx == DONE);
    wr_d   = issue;
    fw_d   = issue && is_full;
    hw_d   = issue && is_half;
    bw_d   = issue && !is_full && !is_half;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_ready      <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      wr_en_display  <= 1'b0;
      byteWrite      <= 1'b0;
      half_wordWrite <= 1'b0;
      full_wordWrite <= 1'b0;
      writeAddress   <= 32'd0;
      x0_q <= '0; y0_q <= '0; w_q <= '0; h_q <= '0;
      x_end_q <= '0; y_end_q <= '0; x_q <= '0; y_q <= '0;
      color_q <= 8'd0;
      fin_q   <= 1'b0;
    end else begin
      cmd_ready      <= rdy_d;
      busy           <= busy_d;
      done           <= done_d;
      wr_en_display  <= wr_d;
      byteWrite      <= bw_d;
      half_wordWrite <= hw_d;
      full_wordWrite <= fw_d;
      if (state == IDLE && cmd_valid) begin
        x0_q    <= {1'b0, cmd_x0};
        y0_q    <= {2'b0, cmd_y0};
        w_q     <= {1'b0, cmd_w};
        h_q     <= {2'b0, cmd_h};
        color_q <= cmd_color;
        fin_q   <= 1'b0;
      end
      if (state == SETUP) begin
        x_end_q <= xe_c;
        y_end_q <= ye_c;
      end
      if (issue) begin
        writeAddress <= addr_c;
        x_q          <= row_end ? x0_q : nx;
        y_q          <= row_end ? sel_y + 11'd1 : sel_y;
        fin_q        <= last;
      end
    end
  end

  assign writeData = {4{color_q}};

endmodule

// File: tb/tb_display_writer.sv
// tb/tb_display_writer.sv - self-checking bench for display_writer
// Table vectors, random rectangles against a pixel-walk model, and reset/back-to-back sequences.
module tb_display_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_x0;
  logic [8:0]  cmd_y0;
  logic [9:0]  cmd_w;
  logic [8:0]  cmd_h;
  logic [7:0]  cmd_color;
  logic        busy, done, wr_en_display, byteWrite, half_wordWrite, full_wordWrite;
  logic [31:0] writeAddress, writeData;

  display_writer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .busy(busy), .done(done), .wr_en_display(wr_en_display), .byteWrite(byteWrite),
    .half_wordWrite(half_wordWrite), .full_wordWrite(full_wordWrite),
    .writeAddress(writeAddress), .writeData(writeData)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    int          size;
    logic [31:0] data;
  } store_t;

  typedef struct {
    int x0, y0, w, h, color;
    int exp_n, exp_addr0, exp_size0;
  } vec_t;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  store_t obs[$];
  store_t exp_q[$];
  int     done_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Record every store and done pulse; strobes must be one-hot with the write enable.
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en_display) begin
        store_t s;
        chk("strobe_onehot", 32'(byteWrite) + 32'(half_wordWrite) + 32'(full_wordWrite), 1);
        s.cyc  = cyc;
        s.addr = writeAddress;
        s.size = full_wordWrite ? 4 : (half_wordWrite ? 2 : (byteWrite ? 1 : 0));
        s.data = writeData;
        obs.push_back(s);
      end else if (byteWrite | half_wordWrite | full_wordWrite) begin
        chk("strobe_idle", {byteWrite, half_wordWrite, full_wordWrite}, 0);
      end
      if (done) done_q.push_back(cyc);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Walk the clipped rectangle pixel by pixel, picking the widest aligned store that fits.
  task automatic build_model(input int x0, input int y0, input int w, input int h, input int color);
    int xe, ye, s;
    store_t e;
    exp_q.delete();
    if (w == 0 || h == 0 || x0 >= 640 || y0 >= 480) return;
    xe = (x0 + w > 640) ? 640 : x0 + w;
    ye = (y0 + h > 480) ? 480 : y0 + h;
    for (int yy = y0; yy < ye; yy++) begin
      for (int xx = x0; xx < xe; xx += s) begin
        if (xx % 4 == 0 && xe - xx >= 4)      s = 4;
        else if (xx % 2 == 0 && xe - xx >= 2) s = 2;
        else                                  s = 1;
        e.cyc  = 0;
        e.addr = 32'(yy * 640 + xx);
        e.size = s;
        e.data = {4{color[7:0]}};
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic send(input int x0, input int y0, input int w, input int h, input int color,
                      output int acc);
    int n;
    n = 0;
    tick();
    while (!cmd_ready && n < 200) begin tick(); n++; end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
    cmd_x0 = 10'(x0); cmd_y0 = 9'(y0); cmd_w = 10'(w); cmd_h = 9'(h); cmd_color = 8'(color);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
  endtask

  task automatic run_cmd(input int x0, input int y0, input int w, input int h, input int color);
    int acc, n, lim;
    obs.delete();
    done_q.delete();
    build_model(x0, y0, w, h, color);
    send(x0, y0, w, h, color, acc);
    tick();
    cmd_valid = 1'b0;
    chk("setup_busy", busy, 1);
    n = 0;
    while (done_q.size() == 0 && n < 3000) begin tick(); n++; end
    if (done_q.size() == 0) begin
      chk("done_timeout", 0, 1);
      return;
    end
    chk("store_count", obs.size(), exp_q.size());
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      chk("store_addr", obs[i].addr, exp_q[i].addr);
      chk("store_size", obs[i].size, exp_q[i].size);
      chk("store_data", obs[i].data, exp_q[i].data);
      chk("store_cycle", obs[i].cyc, acc + 1 + i);
    end
    chk("done_cycle", done_q[0], acc + 1 + exp_q.size());
    tick();
    chk("done_pulse", done, 0);
    chk("ready_after", cmd_ready, 1);
  endtask

  vec_t vt[$];

  initial begin
    int acc, n, d;
    reset = 1'b1; cmd_valid = 1'b0;
    cmd_x0 = '0; cmd_y0 = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    repeat (3) tick();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_strobes", {wr_en_display, byteWrite, half_wordWrite, full_wordWrite}, 0);
    chk("rst_addr", writeAddress, 0);
    chk("rst_data", writeData, 0);
    reset = 1'b0;

    vt.push_back('{0,   0,   1,  1, 8'hA5, 1, 0,      1});
    vt.push_back('{1,   0,   8,  1, 8'h3C, 4, 1,      1});
    vt.push_back('{636, 10,  10, 1, 8'h77, 1, 7036,   4});
    vt.push_back('{638, 479, 2,  2, 8'h0F, 1, 307198, 2});
    vt.push_back('{4,   2,   4,  3, 8'hC3, 3, 1284,   4});
    vt.push_back('{5,   5,   0,  3, 8'h11, 0, 0,      0});
    vt.push_back('{700, 5,   4,  3, 8'h22, 0, 0,      0});
    vt.push_back('{10,  480, 4,  3, 8'h33, 0, 0,      0});
    vt.push_back('{2,   1,   3,  2, 8'h44, 4, 642,    2});
    foreach (vt[i]) begin
      run_cmd(vt[i].x0, vt[i].y0, vt[i].w, vt[i].h, vt[i].color);
      chk("tbl_n", obs.size(), vt[i].exp_n);
      if (vt[i].exp_n > 0) begin
        chk("tbl_addr0", obs[0].addr, vt[i].exp_addr0);
        chk("tbl_size0", obs[0].size, vt[i].exp_size0);
      end
    end

    for (int k = 0; k < 40; k++) begin
      run_cmd($urandom_range(0, 700), $urandom_range(0, 500), $urandom_range(0, 40),
              $urandom_range(0, 5), $urandom_range(0, 255));
    end

    // Reset during the third store of an eight-row fill.
    obs.delete(); done_q.delete();
    send(0, 0, 4, 8, 8'h5A, acc);
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (obs.size() < 3 && n < 50) begin tick(); n++; end
    chk("rst_mid_reach", obs.size(), 3);
    reset = 1'b1;
    tick();
    chk("rst_mid_strobe", {wr_en_display, byteWrite, half_wordWrite, full_wordWrite}, 0);
    chk("rst_mid_ready", cmd_ready, 1);
    chk("rst_mid_busy", busy, 0);
    reset = 1'b0;
    repeat (12) tick();
    chk("rst_mid_nodone", done_q.size(), 0);
    chk("rst_mid_nostore", obs.size(), 3);

    // cmd_valid held high: second command waits for the first IDLE cycle.
    obs.delete(); done_q.delete();
    send(1, 0, 8, 1, 8'h11, acc);
    tick();
    cmd_x0 = 10'd4; cmd_y0 = 9'd2; cmd_w = 10'd4; cmd_h = 9'd1; cmd_color = 8'h22;
    n = 0;
    while (done_q.size() == 0 && n < 50) begin tick(); n++; end
    chk("b2b_done_seen", done_q.size(), 1);
    d = (done_q.size() > 0) ? done_q[0] : 0;
    chk("b2b_done_cycle", d, acc + 5);
    n = 0;
    while (obs.size() < 5 && n < 50) begin tick(); n++; end
    cmd_valid = 1'b0;
    chk("b2b_count", obs.size(), 5);
    if (obs.size() >= 5) begin
      chk("b2b_addr", obs[4].addr, 1284);
      chk("b2b_size", obs[4].size, 4);
      chk("b2b_cycle", obs[4].cyc, d + 3);
      chk("b2b_data", obs[4].data, 32'h22222222);
    end
    repeat (6) tick();
    chk("b2b_once", obs.size(), 5);
    chk("b2b_done2", done_q.size(), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
